// File: rtl/rvvi_trace_pkg.sv
// Shared types and defaults for the RVVI trace packer.
// Optional feature macro: RVVI_ORDER_CHECK_EN (per-hart retire-order gap detection).
package rvvi_trace_pkg;

  localparam int XLEN_DEF  = 64;
  localparam int NHART_DEF = 1;
  localparam int NRET_DEF  = 2;

  // Hart id width; a single hart still carries a 1-bit id field.
  function automatic int hart_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int HART_W = hart_w(NHART_DEF);

  // One retired instruction as produced by the trace source.
  typedef struct packed {
    logic [HART_W-1:0]   hart;
    logic [63:0]         order;
    logic [31:0]         insn;
    logic [XLEN_DEF-1:0] pc;
    logic                trap;
    logic [1:0]          mode;
    logic                x_wen;
    logic [4:0]          x_idx;
    logic [XLEN_DEF-1:0] x_wdata;
  } trace_rec_t;

endpackage

// File: rtl/rvvi_trace_fifo.sv
// Register FIFO of trace records: single push, NRET combinational read
// ports starting at the head, and a pop of 0..NRET entries per cycle.
module rvvi_trace_fifo
  import rvvi_trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int NRET  = 2,
  parameter int CNT_W = $clog2(DEPTH + 1),
  parameter int K_W   = $clog2(NRET + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  trace_rec_t       push_data_i,
  input  logic [K_W-1:0]   pop_cnt_i,
  output logic [CNT_W-1:0] count_o,
  output trace_rec_t       rd_data_o [NRET]
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_MASK = PTR_W'(DEPTH - 1);

  trace_rec_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  // Storage write on accepted push.
  // NOTE: the record array has no reset; occupancy is tracked by count/pointers,
  // so stale contents are never observed and the array can map to plain flops/RAM.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointer and occupancy next state; push and pop-by-k combine in one cycle.
  always_comb begin
    wr_ptr_d = push_i ? ((wr_ptr_q + PTR_W'(1)) & PTR_MASK) : wr_ptr_q;
    rd_ptr_d = (rd_ptr_q + PTR_W'(pop_cnt_i)) & PTR_MASK;
    count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_cnt_i);
  end

  // Pointer and occupancy registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count_o = count_q;

  for (genvar i = 0; i < NRET; i++) begin : g_rd
    assign rd_data_o[i] = mem_q[(rd_ptr_q + PTR_W'(i)) & PTR_MASK];
  end

endmodule

// File: rtl/rvvi_trace_packer.sv
// Buffers single retirement records and packs up to NRET consecutive records
// of one hart per cycle onto registered multi-hart / multi-lane RVVI outputs.
// Optional feature macro: RVVI_ORDER_CHECK_EN -- sticky per-hart order_err on
// a gap between consecutive packed groups; without it order_err is tied to 0.
// The record struct is sized from the package defaults, so XLEN and NHART
// overrides must stay consistent with rvvi_trace_pkg.
module rvvi_trace_packer
  import rvvi_trace_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NHART = NHART_DEF,
  parameter int NRET  = NRET_DEF,
  parameter int DEPTH = 8
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  trace_rec_t                                in_rec,
  input  logic                                      stall,
  output logic [NHART-1:0][NRET-1:0]                rv_valid,
  output logic [NHART-1:0][NRET-1:0][63:0]          rv_order,
  output logic [NHART-1:0][NRET-1:0][31:0]          rv_insn,
  output logic [NHART-1:0][NRET-1:0][XLEN-1:0]      rv_pc,
  output logic [NHART-1:0][NRET-1:0]                rv_trap,
  output logic [NHART-1:0][NRET-1:0][1:0]           rv_mode,
  output logic [NHART-1:0][NRET-1:0][31:0]          rv_x_wb,
  output logic [NHART-1:0][NRET-1:0][31:0][XLEN-1:0] rv_x_wdata,
  output logic [NHART-1:0]                          order_err
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int K_W   = $clog2(NRET + 1);

  logic [CNT_W-1:0] count;
  trace_rec_t       rd_data [NRET];
  trace_rec_t       head;
  logic             push;
  logic [K_W-1:0]   pack_k;
  logic             joined;
  logic             hart_ok;
  logic [HART_W-1:0] pack_hart;

  logic [NHART-1:0][NRET-1:0]                 rv_valid_q,   rv_valid_d;
  logic [NHART-1:0][NRET-1:0][63:0]           rv_order_q,   rv_order_d;
  logic [NHART-1:0][NRET-1:0][31:0]           rv_insn_q,    rv_insn_d;
  logic [NHART-1:0][NRET-1:0][XLEN-1:0]       rv_pc_q,      rv_pc_d;
  logic [NHART-1:0][NRET-1:0]                 rv_trap_q,    rv_trap_d;
  logic [NHART-1:0][NRET-1:0][1:0]            rv_mode_q,    rv_mode_d;
  logic [NHART-1:0][NRET-1:0][31:0]           rv_x_wb_q,    rv_x_wb_d;
  logic [NHART-1:0][NRET-1:0][31:0][XLEN-1:0] rv_x_wdata_q, rv_x_wdata_d;

  // No bypass: readiness comes from registered occupancy, and is held low in reset.
  assign in_ready = reset_n && (count < CNT_W'(DEPTH));
  assign push     = in_valid && in_ready;

  rvvi_trace_fifo #(
    .DEPTH (DEPTH),
    .NRET  (NRET)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (push),
    .push_data_i (in_rec),
    .pop_cnt_i   (pack_k),
    .count_o     (count),
    .rd_data_o   (rd_data)
  );

  assign head      = rd_data[0];
  assign pack_hart = head.hart;
  assign hart_ok   = (int'(head.hart) < NHART);

  // Pack selection: extend the group while entries are same-hart and order-contiguous.
  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    pack_k = '0;
    joined = 1'b1;
    if (!stall && (count != '0)) begin
      pack_k = K_W'(1);
      for (int i = 1; i < NRET; i++) begin
        if (joined && (CNT_W'(i) < count) &&
            (rd_data[i].hart == head.hart) &&
            (rd_data[i].order == head.order + 64'(i))) begin
          pack_k = K_W'(i + 1);
        end else begin
          joined = 1'b0;
        end
      end
    end
  end

  // Output next state: zero every lane, then load the lanes of the packed hart.
  always_comb begin
    rv_valid_d   = '0;
    rv_order_d   = '0;
    rv_insn_d    = '0;
    rv_pc_d      = '0;
    rv_trap_d    = '0;
    rv_mode_d    = '0;
    rv_x_wb_d    = '0;
    rv_x_wdata_d = '0;
    if (hart_ok) begin
      for (int i = 0; i < NRET; i++) begin
        if (K_W'(i) < pack_k) begin
          rv_valid_d[pack_hart][i] = 1'b1;
          rv_order_d[pack_hart][i] = rd_data[i].order;
          rv_insn_d[pack_hart][i]  = rd_data[i].insn;
          rv_pc_d[pack_hart][i]    = rd_data[i].pc;
          rv_trap_d[pack_hart][i]  = rd_data[i].trap;
          rv_mode_d[pack_hart][i]  = rd_data[i].mode;
          // x0 writes are architecturally invisible.
          if (rd_data[i].x_wen && (rd_data[i].x_idx != 5'd0)) begin
            rv_x_wb_d[pack_hart][i][rd_data[i].x_idx]    = 1'b1;
            rv_x_wdata_d[pack_hart][i][rd_data[i].x_idx] = rd_data[i].x_wdata;
          end
        end
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rv_valid_q   <= '0;
      rv_order_q   <= '0;
      rv_insn_q    <= '0;
      rv_pc_q      <= '0;
      rv_trap_q    <= '0;
      rv_mode_q    <= '0;
      rv_x_wb_q    <= '0;
      rv_x_wdata_q <= '0;
    end else begin
      rv_valid_q   <= rv_valid_d;
      rv_order_q   <= rv_order_d;
      rv_insn_q    <= rv_insn_d;
      rv_pc_q      <= rv_pc_d;
      rv_trap_q    <= rv_trap_d;
      rv_mode_q    <= rv_mode_d;
      rv_x_wb_q    <= rv_x_wb_d;
      rv_x_wdata_q <= rv_x_wdata_d;
    end
  end

  assign rv_valid   = rv_valid_q;
  assign rv_order   = rv_order_q;
  assign rv_insn    = rv_insn_q;
  assign rv_pc      = rv_pc_q;
  assign rv_trap    = rv_trap_q;
  assign rv_mode    = rv_mode_q;
  assign rv_x_wb    = rv_x_wb_q;
  assign rv_x_wdata = rv_x_wdata_q;

`ifdef RVVI_ORDER_CHECK_EN
  logic [NHART-1:0][63:0] exp_order_q;
  logic [NHART-1:0]       seen_q;
  logic [NHART-1:0]       order_err_q;

  // Order tracking: flag a gap between the previous group's end and this group's head.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_order_q <= '0;
      seen_q      <= '0;
      order_err_q <= '0;
    end else if ((pack_k != '0) && hart_ok) begin
      if (seen_q[pack_hart] && (head.order != exp_order_q[pack_hart])) begin
        order_err_q[pack_hart] <= 1'b1;
      end
      exp_order_q[pack_hart] <= head.order + 64'(pack_k);
      seen_q[pack_hart]      <= 1'b1;
    end
  end

  assign order_err = order_err_q;
`else
  assign order_err = '0;
`endif

endmodule

// File: tb/tb_rvvi_trace_packer.sv
// Directed bench for rvvi_trace_packer (2 harts, 2 lanes, depth 8).
module tb_rvvi_trace_packer;
  import rvvi_trace_pkg::*;

  localparam int XLEN  = 64;
  localparam int NHART = 2;
  localparam int NRET  = 2;
  localparam int DEPTH = 8;

`ifdef RVVI_ORDER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  trace_rec_t in_rec = '0;
  logic stall = 1'b1;
  logic [NHART-1:0][NRET-1:0]                 rv_valid;
  logic [NHART-1:0][NRET-1:0][63:0]           rv_order;
  logic [NHART-1:0][NRET-1:0][31:0]           rv_insn;
  logic [NHART-1:0][NRET-1:0][XLEN-1:0]       rv_pc;
  logic [NHART-1:0][NRET-1:0]                 rv_trap;
  logic [NHART-1:0][NRET-1:0][1:0]            rv_mode;
  logic [NHART-1:0][NRET-1:0][31:0]           rv_x_wb;
  logic [NHART-1:0][NRET-1:0][31:0][XLEN-1:0] rv_x_wdata;
  logic [NHART-1:0]                           order_err;

  int total = 0;
  int bad   = 0;

  rvvi_trace_packer #(
    .XLEN  (XLEN),
    .NHART (NHART),
    .NRET  (NRET),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rec     (in_rec),
    .stall      (stall),
    .rv_valid   (rv_valid),
    .rv_order   (rv_order),
    .rv_insn    (rv_insn),
    .rv_pc      (rv_pc),
    .rv_trap    (rv_trap),
    .rv_mode    (rv_mode),
    .rv_x_wb    (rv_x_wb),
    .rv_x_wdata (rv_x_wdata),
    .order_err  (order_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic trace_rec_t mk(input int h, input logic [63:0] ord);
    trace_rec_t r;
    r       = '0;
    r.hart  = HART_W'(h);
    r.order = ord;
    r.insn  = 32'h0000_0013;
    r.pc    = 64'h8000_0000 + (ord << 2);
    return r;
  endfunction

  task automatic push(input trace_rec_t r);
    in_rec   = r;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    stall   = 1'b1;
    #3;
    reset_n = 1'b1;
    tick();
  endtask

  trace_rec_t r;

  initial begin
    // Reset state.
    #2;
    check("rst_valid", 64'(rv_valid), 64'h0);
    check("rst_ready", 64'(in_ready), 64'h0);
    check("rst_err",   64'(order_err), 64'h0);
    tick();
    reset_n = 1'b1;
    tick();
    check("idle_ready", 64'(in_ready), 64'h1);

    // Contiguous orders 10,11,12 on hart 0: a 2-lane group then a single.
    push(mk(0, 64'd10));
    push(mk(0, 64'd11));
    push(mk(0, 64'd12));
    check("stalled_valid", 64'(rv_valid), 64'h0);
    stall = 1'b0;
    tick();
    check("p1_valid_h0", 64'(rv_valid[0]), 64'h3);
    check("p1_valid_h1", 64'(rv_valid[1]), 64'h0);
    check("p1_ord_l0",   rv_order[0][0], 64'd10);
    check("p1_ord_l1",   rv_order[0][1], 64'd11);
    check("p1_pc_l1",    rv_pc[0][1], 64'h8000_002C);
    tick();
    check("p2_valid_h0", 64'(rv_valid[0]), 64'h1);
    check("p2_ord_l0",   rv_order[0][0], 64'd12);
    check("p2_ord_l1",   rv_order[0][1], 64'd0);
    tick();
    check("p3_idle", 64'(rv_valid), 64'h0);

    // Hart 0 order 5 then hart 1 order 6: never share a cycle.
    do_reset();
    push(mk(0, 64'd5));
    push(mk(1, 64'd6));
    stall = 1'b0;
    tick();
    check("h_a_valid", 64'(rv_valid), 64'h1);
    check("h_a_ord",   rv_order[0][0], 64'd5);
    tick();
    check("h_b_valid", 64'(rv_valid), 64'h4);
    check("h_b_ord",   rv_order[1][0], 64'd6);
    check("h_b_err",   64'(order_err), 64'h0);
    tick();
    check("h_idle", 64'(rv_valid), 64'h0);

    // Order gap 20,22: packed separately; sticky error when checking is built in.
    do_reset();
    push(mk(0, 64'd20));
    push(mk(0, 64'd22));
    stall = 1'b0;
    tick();
    check("gap_a_valid", 64'(rv_valid), 64'h1);
    check("gap_a_ord",   rv_order[0][0], 64'd20);
    check("gap_a_err",   64'(order_err), 64'h0);
    tick();
    check("gap_b_valid", 64'(rv_valid), 64'h1);
    check("gap_b_ord",   rv_order[0][0], 64'd22);
    check("gap_b_err",   64'(order_err), 64'(CHK));
    tick();
    check("gap_sticky",  64'(order_err), 64'(CHK));

    // Fill to DEPTH under stall, offer one extra, then drain in four 2-lane groups.
    do_reset();
    for (int j = 0; j < DEPTH; j++) begin
      check($sformatf("fill_ready%0d", j), 64'(in_ready), 64'h1);
      push(mk(0, 64'd100 + 64'(j)));
    end
    check("full_ready", 64'(in_ready), 64'h0);
    push(mk(0, 64'd108));
    check("full_still", 64'(in_ready), 64'h0);
    stall = 1'b0;
    for (int j = 0; j < 4; j++) begin
      tick();
      check($sformatf("drain%0d_valid", j), 64'(rv_valid), 64'h3);
      check($sformatf("drain%0d_l0", j), rv_order[0][0], 64'd100 + 64'(2 * j));
      check($sformatf("drain%0d_l1", j), rv_order[0][1], 64'd101 + 64'(2 * j));
      check($sformatf("drain%0d_ready", j), 64'(in_ready), 64'h1);
    end
    tick();
    check("drain_empty", 64'(rv_valid), 64'h0);

    // Register writeback: x0 is suppressed, x5 is one-hot with data.
    do_reset();
    stall = 1'b0;
    r = mk(0, 64'd1);
    r.x_wen = 1'b1; r.x_idx = 5'd0; r.x_wdata = 64'h55;
    push(r);
    check("wb0_latency", 64'(rv_valid), 64'h0);
    tick();
    check("wb0_valid", 64'(rv_valid), 64'h1);
    check("wb0_mask",  64'(rv_x_wb[0][0]), 64'h0);
    check("wb0_data",  64'(rv_x_wdata[0][0] == '0), 64'h1);
    r = mk(0, 64'd2);
    r.x_wen = 1'b1; r.x_idx = 5'd5; r.x_wdata = 64'hDEAD;
    push(r);
    check("wb5_latency", 64'(rv_valid), 64'h0);
    tick();
    check("wb5_valid", 64'(rv_valid), 64'h1);
    check("wb5_mask",  64'(rv_x_wb[0][0]), 64'h20);
    check("wb5_data",  rv_x_wdata[0][0][5], 64'hDEAD);
    check("wb5_other", rv_x_wdata[0][0][4], 64'h0);

    // Asynchronous reset mid-pack with three records still buffered.
    do_reset();
    for (int j = 0; j < 5; j++) push(mk(0, 64'd30 + 64'(j)));
    stall = 1'b0;
    tick();
    check("ar_pre_valid", 64'(rv_valid), 64'h3);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_valid", 64'(rv_valid), 64'h0);
    check("ar_ord",   rv_order[0][0], 64'h0);
    check("ar_ready", 64'(in_ready), 64'h0);
    tick();
    reset_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      check($sformatf("ar_stale%0d", j), 64'(rv_valid), 64'h0);
    end
    check("ar_ready_back", 64'(in_ready), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
